// File: rtl/fetch_sequencer.sv
// Fetch-stage controller: owns the fetch PC, issues one instruction-bus request at a time,
// applies redirects and delivers a registered {pc, instr, exc} bundle to decode.
module fetch_sequencer #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  input  logic        stall,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_valid,
  input  logic [31:0] iresp_data,
  output logic        f_valid,
  output logic [63:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_exc
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StFetch = 3'd1;
  localparam logic [2:0] StHold  = 3'd2;
  localparam logic [2:0] StDrain = 3'd3;
  localparam logic [2:0] StExc   = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] addr_q, addr_d;
  logic [31:0] hold_q, hold_d;
  logic        f_valid_q, f_valid_d;
  logic [63:0] f_pc_q, f_pc_d;
  logic [31:0] f_instr_q, f_instr_d;
  logic        f_exc_q, f_exc_d;

  logic slot_free;
  logic pc_aligned;

  assign slot_free  = !f_valid_q || !stall;
  assign pc_aligned = (pc_q[1:0] == 2'b00);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    hold_d    = hold_q;
    f_valid_d = f_valid_q;
    f_pc_d    = f_pc_q;
    f_instr_d = f_instr_q;
    f_exc_d   = f_exc_q;

    if (f_valid_q && !stall) begin
      f_valid_d = 1'b0;
    end

    if (redirect_valid) begin
      pc_d      = redirect_pc;
      f_valid_d = 1'b0;
      hold_d    = 32'h0;
      unique case (state_q)
        StFetch: begin
          // A live request with no response yet must be drained at its original address.
          if (pc_aligned && !iresp_valid) begin
            state_d = StDrain;
            addr_d  = pc_q;
          end else begin
            state_d = StFetch;
          end
        end
        StDrain: state_d = iresp_valid ? StFetch : StDrain;
        default: state_d = StFetch;
      endcase
    end else begin
      unique case (state_q)
        StIdle: state_d = StFetch;
        StFetch: begin
          if (pc_aligned) begin
            if (iresp_valid) begin
              if (slot_free) begin
                f_valid_d = 1'b1;
                f_pc_d    = pc_q;
                f_instr_d = iresp_data;
                f_exc_d   = 1'b0;
                pc_d      = pc_q + 64'd4;
              end else begin
                hold_d  = iresp_data;
                state_d = StHold;
              end
            end
          end else if (slot_free) begin
            f_valid_d = 1'b1;
            f_pc_d    = pc_q;
            f_instr_d = 32'h0;
            f_exc_d   = 1'b1;
            state_d   = StExc;
          end
        end
        StHold: begin
          if (slot_free) begin
            f_valid_d = 1'b1;
            f_pc_d    = pc_q;
            f_instr_d = hold_q;
            f_exc_d   = 1'b0;
            pc_d      = pc_q + 64'd4;
            state_d   = StFetch;
          end
        end
        StDrain: begin
          if (iresp_valid) begin
            state_d = StFetch;
          end
        end
        StExc:   state_d = StExc;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pc_q      <= RESET_PC;
      addr_q    <= 64'h0;
      hold_q    <= 32'h0;
      f_valid_q <= 1'b0;
      f_pc_q    <= 64'h0;
      f_instr_q <= 32'h0;
      f_exc_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      hold_q    <= hold_d;
      f_valid_q <= f_valid_d;
      f_pc_q    <= f_pc_d;
      f_instr_q <= f_instr_d;
      f_exc_q   <= f_exc_d;
    end
  end

  always_comb begin
    ireq_valid = ((state_q == StFetch) && pc_aligned) || (state_q == StDrain);
    if (state_q == StDrain) begin
      ireq_addr = addr_q;
    end else if (ireq_valid) begin
      ireq_addr = pc_q;
    end else begin
      ireq_addr = 64'h0;
    end
  end

  assign f_valid = f_valid_q;
  assign f_pc    = f_pc_q;
  assign f_instr = f_instr_q;
  assign f_exc   = f_exc_q;

endmodule
